// File: rtl/pipelined_cache_miss_handler_pkg.sv
// Shared types and geometry for the pipelined cache miss/writeback engine.
// The line-address helper builds line-aligned memory addresses from tag and index.
package pipelined_cache_miss_handler_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE   = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    FILL    = 3'd2,
    INSTALL = 3'd3,
    REPLAY  = 3'd4
  } miss_state_t;

  function automatic logic [31:0] line_addr(input logic [S_TAG-1:0]   tag,
                                            input logic [S_INDEX-1:0] idx);
    return {tag, idx, {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/pipelined_cache_miss_handler_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// RST_VAL lets a bench start the count near the ceiling.
module sat_counter32 #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipelined_cache_miss_handler.sv
// Miss/writeback engine behind the stage-2 register: stalls on a miss, writes back
// a dirty victim, fills the line, installs it and replays the request as a hit.
module pipelined_cache_miss_handler
  import pipelined_cache_miss_handler_pkg::*;
#(
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic               hit_i,
  input  logic               dirty_i,
  input  logic               lru_i,
  input  logic               mem_write_i,
  input  logic [31:0]        address_i,
  input  logic [S_TAG-1:0]   victim_tag_i,
  input  logic [S_LINE-1:0]  victim_data_i,
  input  logic [S_LINE-1:0]  pmem_rdata_i,
  input  logic               pmem_resp_i,
  output logic               pmem_read_o,
  output logic               pmem_write_o,
  output logic [31:0]        pmem_address_o,
  output logic [S_LINE-1:0]  pmem_wdata_o,
  output logic               stall_o,
  output logic               fill_we_o,
  output logic               fill_way_o,
  output logic [S_INDEX-1:0] fill_index_o,
  output logic [S_TAG-1:0]   fill_tag_o,
  output logic [S_LINE-1:0]  fill_data_o,
  output logic [31:0]        miss_count_o,
  output logic [31:0]        wb_count_o
);

  miss_state_t        r_state, w_state_nxt;
  logic [31:0]        r_addr;
  logic               r_way;
  logic               r_mem_write;
  logic [S_TAG-1:0]   r_vtag;
  logic [S_LINE-1:0]  r_vdata;
  logic [S_LINE-1:0]  r_fill_data;
  logic               r_pmem_read, r_pmem_write, r_fill_we;
  logic [31:0]        r_pmem_addr, w_pmem_addr_nxt;
  logic               w_miss, w_wb_done;

  // Gating with rst keeps stall low while reset is held, even if stage 2 still shows a miss.
  assign w_miss    = rst & (r_state == IDLE) & req_valid_i & ~hit_i;
  assign w_wb_done = (r_state == WB) & pmem_resp_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_pmem_addr_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_state_nxt     = dirty_i ? WB : FILL;
          w_pmem_addr_nxt = dirty_i ? line_addr(victim_tag_i, address_i[S_OFFSET +: S_INDEX])
                                    : line_addr(address_i[31 -: S_TAG], address_i[S_OFFSET +: S_INDEX]);
        end
      end
      WB: begin
        w_pmem_addr_nxt = r_pmem_addr;
        if (pmem_resp_i) begin
          w_state_nxt     = FILL;
          w_pmem_addr_nxt = line_addr(r_addr[31 -: S_TAG], r_addr[S_OFFSET +: S_INDEX]);
        end
      end
      FILL: begin
        w_pmem_addr_nxt = r_pmem_addr;
        if (pmem_resp_i) begin
          w_state_nxt     = INSTALL;
          w_pmem_addr_nxt = '0;
        end
      end
      INSTALL: w_state_nxt = REPLAY;
      REPLAY:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side strobes are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_fill_we    <= 1'b0;
      r_pmem_addr  <= '0;
      r_addr       <= '0;
      r_way        <= 1'b0;
      r_mem_write  <= 1'b0;
      r_vtag       <= '0;
      r_vdata      <= '0;
      r_fill_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pmem_read  <= (w_state_nxt == FILL);
      r_pmem_write <= (w_state_nxt == WB);
      r_fill_we    <= (w_state_nxt == INSTALL);
      r_pmem_addr  <= w_pmem_addr_nxt;
      if (w_miss) begin
        r_addr      <= address_i;
        r_way       <= lru_i;
        r_mem_write <= mem_write_i;
        r_vtag      <= victim_tag_i;
        r_vdata     <= victim_data_i;
      end
      if ((r_state == FILL) && pmem_resp_i) begin
        r_fill_data <= pmem_rdata_i;
      end
    end
  end

  assign stall_o        = (r_state != IDLE) | w_miss;
  assign pmem_read_o    = r_pmem_read;
  assign pmem_write_o   = r_pmem_write;
  assign pmem_address_o = r_pmem_addr;
  assign pmem_wdata_o   = r_vdata;
  assign fill_we_o      = r_fill_we;
  assign fill_way_o     = r_way;
  assign fill_index_o   = r_addr[S_OFFSET +: S_INDEX];
  assign fill_tag_o     = r_addr[31 -: S_TAG];
  assign fill_data_o    = r_fill_data;

  sat_counter32 #(.RST_VAL(CNT_INIT)) u_miss_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_inc   (w_miss),
    .o_count (miss_count_o)
  );

  sat_counter32 #(.RST_VAL(CNT_INIT)) u_wb_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_inc   (w_wb_done),
    .o_count (wb_count_o)
  );

endmodule

// File: tb/tb_pipelined_cache_miss_handler.sv
// Directed bench for the cache miss handler; a second instance starts its counters
// near the ceiling to exercise saturation.
module tb_pipelined_cache_miss_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_i, hit_i, dirty_i, lru_i, mem_write_i, pmem_resp_i;
  logic [31:0]  address_i;
  logic [23:0]  victim_tag_i;
  logic [255:0] victim_data_i, pmem_rdata_i;

  logic         pmem_read_o, pmem_write_o, stall_o, fill_we_o, fill_way_o;
  logic [31:0]  pmem_address_o, miss_count_o, wb_count_o;
  logic [255:0] pmem_wdata_o, fill_data_o;
  logic [2:0]   fill_index_o;
  logic [23:0]  fill_tag_o;

  logic         s_pmem_read, s_pmem_write, s_stall, s_fill_we, s_fill_way;
  logic [31:0]  s_pmem_address, s_miss_count, s_wb_count;
  logic [255:0] s_pmem_wdata, s_fill_data;
  logic [2:0]   s_fill_index;
  logic [23:0]  s_fill_tag;

  int total = 0;
  int bad   = 0;

  logic [255:0] c_a5   = {32{8'hA5}};
  logic [255:0] c_dead = {8{32'hDEAD_BEEF}};
  logic [255:0] c_1234 = {8{32'h1234_5678}};

  always #5 clk = ~clk;

  pipelined_cache_miss_handler dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .hit_i(hit_i), .dirty_i(dirty_i),
    .lru_i(lru_i), .mem_write_i(mem_write_i), .address_i(address_i),
    .victim_tag_i(victim_tag_i), .victim_data_i(victim_data_i),
    .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
    .pmem_address_o(pmem_address_o), .pmem_wdata_o(pmem_wdata_o), .stall_o(stall_o),
    .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_index_o(fill_index_o),
    .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o),
    .miss_count_o(miss_count_o), .wb_count_o(wb_count_o)
  );

  pipelined_cache_miss_handler #(.CNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .hit_i(hit_i), .dirty_i(dirty_i),
    .lru_i(lru_i), .mem_write_i(mem_write_i), .address_i(address_i),
    .victim_tag_i(victim_tag_i), .victim_data_i(victim_data_i),
    .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i),
    .pmem_read_o(s_pmem_read), .pmem_write_o(s_pmem_write),
    .pmem_address_o(s_pmem_address), .pmem_wdata_o(s_pmem_wdata), .stall_o(s_stall),
    .fill_we_o(s_fill_we), .fill_way_o(s_fill_way), .fill_index_o(s_fill_index),
    .fill_tag_o(s_fill_tag), .fill_data_o(s_fill_data),
    .miss_count_o(s_miss_count), .wb_count_o(s_wb_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic dirty);
    req_valid_i = 1'b1; hit_i = 1'b0; dirty_i = dirty; address_i = addr;
    tick();
    pmem_resp_i = 1'b1;
    if (dirty) tick();
    tick();
    pmem_resp_i = 1'b0;
    tick();
    hit_i = 1'b1;
    tick();
    req_valid_i = 1'b0; hit_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid_i = 0; hit_i = 0; dirty_i = 0; lru_i = 0; mem_write_i = 0;
    pmem_resp_i = 0; address_i = '0; victim_tag_i = '0; victim_data_i = '0; pmem_rdata_i = '0;
    tick(); tick();
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b exp 0", stall_o); end
    total++; if ({pmem_read_o, pmem_write_o, fill_we_o} !== 3'b000) begin bad++; $display("FAIL rst_strobes: got %b exp 000", {pmem_read_o, pmem_write_o, fill_we_o}); end
    total++; if (pmem_address_o !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h exp 0", pmem_address_o); end
    total++; if (miss_count_o !== 32'h0 || wb_count_o !== 32'h0) begin bad++; $display("FAIL rst_counts: got %h/%h exp 0/0", miss_count_o, wb_count_o); end
    total++; if (fill_data_o !== '0 || pmem_wdata_o !== '0) begin bad++; $display("FAIL rst_data: got nonzero exp 0"); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_clean_miss();
    req_valid_i = 1; hit_i = 0; dirty_i = 0; lru_i = 1; mem_write_i = 0;
    address_i = 32'h0000_1240; victim_tag_i = 24'h777777; victim_data_i = c_dead;
    #1;
    total++; if (stall_o !== 1'b1 || pmem_read_o !== 1'b0) begin bad++; $display("FAIL clean_detect: stall=%b read=%b exp 1/0", stall_o, pmem_read_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0 || pmem_address_o !== 32'h0000_1240) begin
        bad++; $display("FAIL clean_fill_req: read=%b write=%b addr=%h exp 1/0/00001240", pmem_read_o, pmem_write_o, pmem_address_o); end
      tick();
    end
    pmem_resp_i = 1; pmem_rdata_i = c_a5;
    tick();
    pmem_resp_i = 0;
    total++; if (fill_we_o !== 1'b1 || fill_way_o !== 1'b1 || fill_index_o !== 3'b010 || fill_tag_o !== 24'h000012) begin
      bad++; $display("FAIL clean_install: we=%b way=%b idx=%b tag=%h exp 1/1/010/000012", fill_we_o, fill_way_o, fill_index_o, fill_tag_o); end
    total++; if (fill_data_o !== c_a5 || pmem_read_o !== 1'b0 || stall_o !== 1'b1) begin bad++; $display("FAIL clean_install_data: read=%b stall=%b exp 0/1", pmem_read_o, stall_o); end
    tick();
    total++; if (fill_we_o !== 1'b0 || stall_o !== 1'b1) begin bad++; $display("FAIL clean_replay: we=%b stall=%b exp 0/1", fill_we_o, stall_o); end
    hit_i = 1;
    tick();
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL clean_release: stall=%b exp 0", stall_o); end
    total++; if (miss_count_o !== 32'd1 || wb_count_o !== 32'd0) begin bad++; $display("FAIL clean_counts: got %0d/%0d exp 1/0", miss_count_o, wb_count_o); end
  endtask

  task automatic test_dirty_miss();
    req_valid_i = 1; hit_i = 0; dirty_i = 1; lru_i = 0; mem_write_i = 1;
    address_i = 32'h0000_1240; victim_tag_i = 24'hABCDEF; victim_data_i = c_dead;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL dirty_detect: stall=%b exp 1", stall_o); end
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (pmem_write_o !== 1'b1 || pmem_read_o !== 1'b0 || pmem_address_o !== 32'hABCD_EF40 || pmem_wdata_o !== c_dead) begin
        bad++; $display("FAIL dirty_wb: write=%b read=%b addr=%h exp 1/0/abcdef40", pmem_write_o, pmem_read_o, pmem_address_o); end
      tick();
    end
    pmem_resp_i = 1;
    tick();
    pmem_resp_i = 0;
    total++; if (pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0 || pmem_address_o !== 32'h0000_1240) begin
      bad++; $display("FAIL dirty_fill: read=%b write=%b addr=%h exp 1/0/00001240", pmem_read_o, pmem_write_o, pmem_address_o); end
    total++; if (wb_count_o !== 32'd1) begin bad++; $display("FAIL dirty_wbcount: got %0d exp 1", wb_count_o); end
    tick();
    total++; if (pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0) begin bad++; $display("FAIL dirty_fill_hold: read=%b write=%b exp 1/0", pmem_read_o, pmem_write_o); end
    pmem_resp_i = 1; pmem_rdata_i = c_1234;
    tick();
    pmem_resp_i = 0;
    total++; if (fill_we_o !== 1'b1 || fill_way_o !== 1'b0 || fill_tag_o !== 24'h000012 || fill_data_o !== c_1234) begin
      bad++; $display("FAIL dirty_install: we=%b way=%b tag=%h exp 1/0/000012", fill_we_o, fill_way_o, fill_tag_o); end
    tick();
    hit_i = 1;
    tick();
    total++; if (stall_o !== 1'b0 || miss_count_o !== 32'd2 || wb_count_o !== 32'd1) begin
      bad++; $display("FAIL dirty_end: stall=%b counts=%0d/%0d exp 0/2/1", stall_o, miss_count_o, wb_count_o); end
  endtask

  task automatic test_hit_traffic();
    req_valid_i = 1; hit_i = 1; dirty_i = 1;
    for (int i = 0; i < 10; i++) begin
      address_i = 32'h0000_0100 + 32'(i * 32);
      #1;
      total++; if (stall_o !== 1'b0 || pmem_read_o !== 1'b0 || pmem_write_o !== 1'b0) begin
        bad++; $display("FAIL hit_quiet: cyc=%0d stall=%b read=%b write=%b exp 0/0/0", i, stall_o, pmem_read_o, pmem_write_o); end
      tick();
    end
    total++; if (miss_count_o !== 32'd2 || wb_count_o !== 32'd1) begin bad++; $display("FAIL hit_counts: got %0d/%0d exp 2/1", miss_count_o, wb_count_o); end
  endtask

  task automatic test_zero_latency();
    int stall_cycles = 0;
    req_valid_i = 1; hit_i = 0; dirty_i = 0; lru_i = 0; address_i = 32'h0000_2360;
    #1; if (stall_o) stall_cycles++;
    tick(); if (stall_o) stall_cycles++;
    total++; if (pmem_read_o !== 1'b1 || pmem_address_o !== 32'h0000_2360) begin bad++; $display("FAIL zl_fill: read=%b addr=%h exp 1/00002360", pmem_read_o, pmem_address_o); end
    pmem_resp_i = 1; pmem_rdata_i = c_a5;
    tick(); if (stall_o) stall_cycles++;
    pmem_resp_i = 0;
    total++; if (fill_we_o !== 1'b1 || fill_index_o !== 3'b011 || fill_tag_o !== 24'h000023 || fill_data_o !== c_a5) begin
      bad++; $display("FAIL zl_install: we=%b idx=%b tag=%h exp 1/011/000023", fill_we_o, fill_index_o, fill_tag_o); end
    tick(); if (stall_o) stall_cycles++;
    hit_i = 1;
    tick(); if (stall_o) stall_cycles++;
    total++; if (stall_cycles != 4) begin bad++; $display("FAIL zl_penalty: got %0d exp 4", stall_cycles); end
    total++; if (miss_count_o !== 32'd3) begin bad++; $display("FAIL zl_count: got %0d exp 3", miss_count_o); end
  endtask

  task automatic test_spurious_reset();
    req_valid_i = 0; hit_i = 0; pmem_resp_i = 1;
    tick();
    pmem_resp_i = 0;
    total++; if ({stall_o, pmem_read_o, pmem_write_o, fill_we_o} !== 4'b0000) begin
      bad++; $display("FAIL spur_idle: got %b exp 0000", {stall_o, pmem_read_o, pmem_write_o, fill_we_o}); end
    req_valid_i = 1; dirty_i = 1; address_i = 32'h0000_1240; victim_tag_i = 24'hABCDEF;
    tick();
    total++; if (pmem_write_o !== 1'b1) begin bad++; $display("FAIL rstwb_pre: write=%b exp 1", pmem_write_o); end
    #2; rst = 0; #1;
    total++; if (pmem_write_o !== 1'b0 || stall_o !== 1'b0 || pmem_read_o !== 1'b0) begin
      bad++; $display("FAIL rstwb_async: write=%b stall=%b read=%b exp 0/0/0", pmem_write_o, stall_o, pmem_read_o); end
    total++; if (miss_count_o !== 32'd0 || wb_count_o !== 32'd0) begin bad++; $display("FAIL rstwb_counts: got %0d/%0d exp 0/0", miss_count_o, wb_count_o); end
    total++; if (s_miss_count !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rstwb_preload: got %h exp fffffffe", s_miss_count); end
    req_valid_i = 0; dirty_i = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_saturation();
    do_miss(32'h0000_1240, 1'b1);
    total++; if (s_miss_count !== 32'hFFFF_FFFF || s_wb_count !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_first: got %h/%h exp ffffffff/ffffffff", s_miss_count, s_wb_count); end
    do_miss(32'h0000_3480, 1'b1);
    total++; if (s_miss_count !== 32'hFFFF_FFFF || s_wb_count !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_hold: got %h/%h exp ffffffff/ffffffff", s_miss_count, s_wb_count); end
    total++; if (miss_count_o !== 32'd2 || wb_count_o !== 32'd2) begin bad++; $display("FAIL sat_ref: got %0d/%0d exp 2/2", miss_count_o, wb_count_o); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_hit_traffic();
    test_zero_latency();
    test_spurious_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cache_miss_handler.md
Name: pipelined_cache_miss_handler

Overview:
Miss/writeback engine for the pipelined cache. It sits after the stage-2 pipeline register and consumes the registered lookup result: hit, dirty, lru, address and mem_write. On a miss it stalls the pipeline, writes back a dirty victim to physical memory, fills the line, then releases the stall so the request replays as a hit. It is the consumer/control end of the stage-2 register interface and the initiator toward the cacheline adaptor.

Parameters:
S_OFFSET, 5, byte-offset bits (32-byte line)
S_INDEX, 3, set-index bits
S_TAG, 24, tag bits (32 - S_OFFSET - S_INDEX)
S_LINE, 256, line width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid_i  in  1  stage-2 holds a live CPU read/write
hit_i  in  1  registered hit
dirty_i  in  1  registered victim dirty bit
lru_i  in  1  registered LRU way (victim way)
mem_write_i  in  1  request is a store
address_i  in  32  registered request address
victim_tag_i  in  S_TAG  tag stored in victim way
victim_data_i  in  S_LINE  data stored in victim way
pmem_rdata_i  in  S_LINE  fill data from adaptor
pmem_resp_i  in  1  adaptor completion, one-cycle pulse
pmem_read_o  out  1  fill request
pmem_write_o  out  1  writeback request
pmem_address_o  out  32  line-aligned memory address
pmem_wdata_o  out  S_LINE  writeback data
stall_o  out  1  freeze stage-1/stage-2 registers (drives their load low)
fill_we_o  out  1  one-cycle write of fill line into arrays
fill_way_o  out  1  way to fill
fill_index_o  out  S_INDEX  set to fill
fill_tag_o  out  S_TAG  tag to install
fill_data_o  out  S_LINE  line to install (valid=1, dirty=0)
miss_count_o  out  32  saturating miss counter
wb_count_o  out  32  saturating writeback counter

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; latched address/way/data cleared; counters 0.
- States:
  - IDLE: stall_o=0. If req_valid_i & ~hit_i: latch address_i, lru_i, victim_tag_i and victim_data_i; assert stall_o combinationally the same cycle; miss_count_o +1. Next state is WB if dirty_i, else FILL.
  - WB: pmem_write_o=1; pmem_address_o={victim_tag, index, 5'b0}; pmem_wdata_o=latched victim data. All three held stable until pmem_resp_i. On resp: wb_count_o +1, go to FILL.
  - FILL: pmem_read_o=1; pmem_address_o={latched tag, index, 5'b0}, held until pmem_resp_i. On resp: latch pmem_rdata_i, go to INSTALL.
  - INSTALL: fill_we_o=1 for exactly one cycle; fill_way/index/tag/data from latched values. Go to REPLAY.
  - REPLAY: stall_o=1 for one cycle so stage 1 re-reads the arrays; go to IDLE. The replayed request must then hit; the store merge is handled by the hit path, not here.
- stall_o=1 in every state except IDLE. In IDLE, stall_o equals the miss-detect term.
- pmem_read_o and pmem_write_o are never both 1. Both are registered, so no glitches.
- Stall-to-memory latency: first pmem request is asserted the cycle after miss detection.
- Minimum miss penalty:
  - clean: 1 (detect) + FILL + 1 + 1 cycles
  - dirty: additionally WB cycles
- pmem_resp_i in IDLE, INSTALL or REPLAY is ignored.
- pmem_resp_i arriving the same cycle the request first rises is accepted.
- req_valid_i with hit_i=1 in IDLE: no action.
- Inputs other than pmem_* are ignored outside IDLE, since stage-2 is frozen.
- mem_write_i does not alter the sequence; it is latched for debug only.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Reset mid-operation drops pmem_read_o/pmem_write_o immediately (async). The adaptor must tolerate an abandoned request.

Decomposition:
- Shared package (rv32i_types or the cache package): enum miss_state_t {IDLE, WB, FILL, INSTALL, REPLAY}; line-width, offset, index and tag width constants.
- One natural sub-module: sat_counter32 (async active-low reset, inc input, saturating), instantiated twice.

Test Plan:
- Clean read miss: address_i=32'h0000_1240, hit_i=0, dirty_i=0, lru_i=1; resp after 4 cycles with rdata=256'hA5… -> pmem_read_o high with address 32'h0000_1240; then fill_we_o=1 for 1 cycle with way=1, index=3'b010, tag=24'h000012; stall drops after REPLAY; miss_count_o=1, wb_count_o=0.
- Dirty miss: victim_tag_i=24'hABCDEF, index 3'b010 -> pmem_write_o first with address 32'hABCD_EF40 and victim data; then pmem_read_o; wb_count_o=1; read and write never overlap.
- Hit traffic: 10 cycles req_valid_i=1, hit_i=1 -> stall_o=0 throughout, no pmem activity, counters unchanged.
- Zero-latency resp: pmem_resp_i asserted in the first FILL cycle -> transition to INSTALL on the next edge; total stall = 4 cycles for a clean miss.
- Spurious resp in IDLE plus reset mid-WB -> resp ignored; rst low during WB clears pmem_write_o and stall_o asynchronously (before the next clk edge); counters read 0.
- Saturation: force miss_count_o to 32'hFFFF_FFFE via back-to-back misses or a preload hook -> two more misses leave it at 32'hFFFF_FFFF.
